// File: rtl/jtag_types_pkg.sv
// Types and constants shared by the JTAG-side FIFO blocks.
package jtag_types_pkg;

    localparam int FIFO_DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
    } fifo_status_t;

endpackage : jtag_types_pkg

// File: rtl/flex_fifo_ptr.sv
// Wrapping FIFO pointer counter with synchronous flush and synchronous active-low reset.
module flex_fifo_ptr #(
    parameter int W = 5
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule : flex_fifo_ptr

// File: rtl/flex_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a flex_fifo_mem array.
// Optional sticky overflow/underflow flags with FLEX_FIFO_CTRL_ERR_EN.
module flex_fifo_ctrl
    import jtag_types_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = FIFO_DEFAULT_DEPTH,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int AFULL_THRESH   = 12,
    localparam int PTR_W         = $clog2(DEPTH)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      clear,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     wdata_in,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     rdata_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic [PTR_W:0]            count,
    output logic                      mem_wclk,
    output logic                      mem_wclk_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
`ifdef FLEX_FIFO_CTRL_ERR_EN
    input  logic                      err_clr,
    output logic                      overflow,
    output logic                      underflow,
`endif
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam logic [PTR_W:0] AFULL_T = AFULL_THRESH[PTR_W:0];

    logic [PTR_W:0] wptr;
    logic [PTR_W:0] rptr;
    logic           push_ok;
    logic           pop_ok;
    fifo_status_t   status;

    flex_fifo_ptr #(.W(PTR_W + 1)) u_wptr (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (clear),
        .inc   (push_ok),
        .ptr   (wptr)
    );

    flex_fifo_ptr #(.W(PTR_W + 1)) u_rptr (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (clear),
        .inc   (pop_ok),
        .ptr   (rptr)
    );

    // Wrap bit distinguishes full from empty when the low bits match.
    always_comb begin
        count              = wptr - rptr;
        status.empty       = (wptr == rptr);
        status.full        = (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]) && (wptr[PTR_W] != rptr[PTR_W]);
        status.almost_full = (count >= AFULL_T);
    end

    assign pop_ok  = pop & ~status.empty;
    assign push_ok = push & (~status.full | pop_ok);

    assign full        = status.full;
    assign empty       = status.empty;
    assign almost_full = status.almost_full;

    assign mem_wclk    = CLK;
    assign mem_wclk_en = push_ok & nRST & ~clear;
    assign mem_wdata   = wdata_in;
    assign mem_waddr   = {{(MEM_ADDR_WIDTH - PTR_W){1'b0}}, wptr[PTR_W-1:0]};
    assign mem_raddr   = {{(MEM_ADDR_WIDTH - PTR_W){1'b0}}, rptr[PTR_W-1:0]};
    assign rdata_out   = mem_rdata;

`ifdef FLEX_FIFO_CTRL_ERR_EN
    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & ~push_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (pop & ~pop_ok) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule : flex_fifo_ctrl

// File: tb/tb_flex_fifo_ctrl.sv
// Self-checking bench for flex_fifo_ctrl against a queue-based reference model.
module tb_flex_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int AFULL = 12;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          clear;
    logic          push;
    logic [DW-1:0] wdata_in;
    logic          pop;
    logic [DW-1:0] rdata_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [4:0]    count;
    logic          mem_wclk;
    logic          mem_wclk_en;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef FLEX_FIFO_CTRL_ERR_EN
    logic          err_clr;
    logic          overflow;
    logic          underflow;
    logic          m_ov;
    logic          m_un;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] model_q [$];
    int            wcnt;
    int            rcnt;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 CLK = ~CLK;

    flex_fifo_ctrl #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .MEM_ADDR_WIDTH (AW),
        .AFULL_THRESH   (AFULL)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .clear       (clear),
        .push        (push),
        .wdata_in    (wdata_in),
        .pop         (pop),
        .rdata_out   (rdata_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .mem_wclk    (mem_wclk),
        .mem_wclk_en (mem_wclk_en),
        .mem_waddr   (mem_waddr),
        .mem_raddr   (mem_raddr),
        .mem_wdata   (mem_wdata),
`ifdef FLEX_FIFO_CTRL_ERR_EN
        .err_clr     (err_clr),
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .mem_rdata   (mem_rdata)
    );

    // Storage array standing in for flex_fifo_mem.
    always @(posedge mem_wclk) begin
        if (mem_wclk_en) mem[mem_waddr[3:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_raddr[3:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int sz;
        sz = model_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(sz >= AFULL));
        chk("mem_waddr", mem_waddr, 32'(wcnt));
        chk("mem_raddr", mem_raddr, 32'(rcnt));
        if (sz > 0) chk("rdata_out", 32'(rdata_out), 32'(model_q[0]));
`ifdef FLEX_FIFO_CTRL_ERR_EN
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
`endif
    endtask

    // One clock cycle: drive at the falling edge, check before and after the rising edge.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic q,
                        input logic clr, input logic ec);
        logic pop_acc;
        logic push_acc;
        push     = p;
        wdata_in = d;
        pop      = q;
        clear    = clr;
`ifdef FLEX_FIFO_CTRL_ERR_EN
        err_clr  = ec;
`else
        if (ec) begin end
`endif
        #1;
        pop_acc  = q && (model_q.size() > 0);
        push_acc = p && ((model_q.size() < DEPTH) || pop_acc);
        chk("wclk_en", 32'(mem_wclk_en), 32'(!clr && push_acc));
        if (model_q.size() > 0) chk("rdata_pre", 32'(rdata_out), 32'(model_q[0]));
        @(posedge CLK);
        if (clr) begin
            model_q.delete();
            wcnt = 0;
            rcnt = 0;
        end else begin
            if (pop_acc) begin
                void'(model_q.pop_front());
                rcnt = (rcnt + 1) % DEPTH;
            end
            if (push_acc) begin
                model_q.push_back(d);
                wcnt = (wcnt + 1) % DEPTH;
            end
        end
`ifdef FLEX_FIFO_CTRL_ERR_EN
        if (p && !push_acc) m_ov = 1'b1; else if (ec) m_ov = 1'b0;
        if (q && !pop_acc)  m_un = 1'b1; else if (ec) m_un = 1'b0;
`endif
        @(negedge CLK);
        check_status();
    endtask

    task automatic do_reset();
        nRST  = 1'b0;
        push  = 1'b1;
        pop   = 1'b0;
        clear = 1'b0;
        #1;
        chk("wclk_en_in_reset", 32'(mem_wclk_en), 32'(0));
        @(posedge CLK);
        model_q.delete();
        wcnt = 0;
        rcnt = 0;
`ifdef FLEX_FIFO_CTRL_ERR_EN
        m_ov = 1'b0;
        m_un = 1'b0;
`endif
        @(negedge CLK);
        nRST = 1'b1;
        push = 1'b0;
        #1;
        check_status();
    endtask

    initial begin
        nRST     = 1'b0;
        clear    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        wdata_in = '0;
        wcnt     = 0;
        rcnt     = 0;
`ifdef FLEX_FIFO_CTRL_ERR_EN
        err_clr  = 1'b0;
        m_ov     = 1'b0;
        m_un     = 1'b0;
`endif
        @(negedge CLK);
        do_reset();

        // Fill to full with 0x00..0x0F; waddr ends wrapped at 0.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("waddr_wrap", mem_waddr, 32'(0));
        chk("full_after_fill", 32'(full), 32'(1));

        // Push into full FIFO is dropped.
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Push and pop together while full: head 0x00 leaves, 0x01 becomes head.
        step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        chk("head_after_swap", 32'(rdata_out), 32'h01);
        chk("count_after_swap", 32'(count), 32'(16));

        // Drain completely.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Push with pop on empty: pop rejected, push lands.
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("fwft_55", 32'(rdata_out), 32'h55);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Load five words, then clear alongside a push.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("empty_after_clear", 32'(empty), 32'(1));

        // Reset in the middle of operation discards contents.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flex_fifo_ctrl

// File: doc/flex_fifo_ctrl.md
# flex_fifo_ctrl

Single-clock FIFO controller that sequences a `flex_fifo_mem` storage array through its `FIFO` modport. It owns the read and write pointers, the occupancy count and the full, empty and almost-full status. It presents a first-word-fall-through push/pop interface to JTAG-side producers and consumers. It sits between the TAP data-register logic and the FIFO memory, and is the only block that drives the memory's write enable and addresses.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; must match the memory instance.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `MEM_ADDR_WIDTH`, 32: width of the memory address ports.
- `AFULL_THRESH`, 12: `almost_full` asserts when `count` ≥ this value; legal range 1..`DEPTH`.
- Derived localparam `PTR_W` = $clog2(`DEPTH`).

Ports:
- `CLK`  in  1  system clock; the only clock.
- `nRST`  in  1  reset, synchronous, active-low.
- `clear`  in  1  synchronous flush.
- `push`  in  1  write request.
- `wdata_in`  in  DATA_WIDTH  write data.
- `pop`  in  1  read request.
- `rdata_out`  out  DATA_WIDTH  head-of-FIFO data; valid while `!empty`.
- `full`  out  1  FIFO full.
- `empty`  out  1  FIFO empty.
- `almost_full`  out  1  `count` ≥ `AFULL_THRESH`.
- `count`  out  PTR_W+1  occupancy.
- `mem_wclk`  out  1  equals `CLK`.
- `mem_wclk_en`  out  1  memory write enable.
- `mem_waddr`  out  MEM_ADDR_WIDTH  write address.
- `mem_raddr`  out  MEM_ADDR_WIDTH  read address.
- `mem_wdata`  out  DATA_WIDTH  equals `wdata_in`.
- `mem_rdata`  in  DATA_WIDTH  combinational read data at `mem_raddr`.
- `overflow`, `underflow`, `err_clr`: present only with `FLEX_FIFO_CTRL_ERR_EN` (see Configuration).

## Operation
- Pointers:
  - `wptr` and `rptr` are each PTR_W+1 bits; the MSB is a wrap bit.
  - `mem_waddr` = zero-extended `wptr[PTR_W-1:0]`. `mem_raddr` = zero-extended `rptr[PTR_W-1:0]`.
- Status:
  - `empty` = (`wptr` == `rptr`).
  - `full` = low bits equal and wrap bits differ.
  - `count` = `wptr` − `rptr`, modulo 2^(PTR_W+1).
- Pop: `pop_ok` = `pop` & `!empty`. On `pop_ok`, `rptr` increments.
- Push: `push_ok` = `push` & (`!full` | `pop_ok`).
  - A push while full is accepted only when a pop is accepted in the same cycle.
  - `mem_wclk_en` = `push_ok` (combinational). On `push_ok`, `wptr` increments.
- Push and pop accepted together: both pointers advance and `count` is unchanged.
- Push while empty with pop asserted: pop is rejected and the push is accepted.
- `rdata_out` = `mem_rdata`, giving first-word-fall-through behaviour.
- `clear` has priority over `push` and `pop`:
  - Both pointers go to 0.
  - `mem_wclk_en` is forced to 0 in that cycle.
- While `nRST`=0, `mem_wclk_en` is forced to 0.
- Pointer wrap is natural modulo arithmetic. There is no special case at `DEPTH`−1.

## Timing
- Reset (`nRST` low at a rising edge):
  - Pointers = 0, `empty`=1, `full`=0, `almost_full`=0, `count`=0.
  - Addresses = 0, `mem_wclk_en`=0, error flags = 0.
- Reset asserted mid-operation discards all contents at that edge.
- Write latency: a push accepted in cycle N writes at the end-of-N edge. `empty` falls and `rdata_out` is valid in N+1.
- Pop: the head is consumed at the end-of-N edge. The next word appears on `rdata_out` in N+1.
- All status outputs derive combinationally from the registered pointers, so they change only just after a clock edge.

## Configuration
- `FLEX_FIFO_CTRL_ERR_EN` defined:
  - Adds ports `err_clr` (in, 1), `overflow` (out, 1) and `underflow` (out, 1).
  - `overflow` sets on `push` & !`push_ok`. `underflow` sets on `pop` & !`pop_ok`.
  - Both flags are sticky. `err_clr` or reset clears them; set has priority over `err_clr` in the same cycle.
  - `clear` does not affect the error flags.
- Macro undefined: these ports and flags are absent. Rejected requests are silently dropped.

## Structure
- Shared package `jtag_types_pkg`:
  - `fifo_status_t` packed struct {`full`, `empty`, `almost_full`}.
  - Constant `FIFO_DEFAULT_DEPTH` = 16.
- Sub-module `flex_fifo_ptr`: a PTR_W+1-bit counter with inputs `clear` and `inc`, and synchronous active-low reset. It is instantiated twice, for write and read.

## Test plan
- Reset, then 16 pushes of 0x00..0x0F with no pop:
  - `count` steps 1..16.
  - `almost_full` rises when `count`=12; `full` rises when `count`=16.
  - `mem_waddr` wraps back to 0.
- Full FIFO with push of 0xAA and no pop: `mem_wclk_en` stays 0 and `count` stays 16. With `FLEX_FIFO_CTRL_ERR_EN`, `overflow`=1 until `err_clr`.
- Full FIFO with push and pop together: `rdata_out` shows 0x00 in that cycle, `count` stays 16, and the next head is 0x01.
- Empty FIFO with push of 0x55 and pop together:
  - The pop is rejected and `underflow`=1 (with the macro).
  - Next cycle `empty`=0 and `rdata_out`=0x55.
- Load 5 words, then pulse `clear` together with a push of 0x77: `empty`=1, `count`=0, and the write is suppressed.
- Random push/pop for 1000 cycles against a scoreboard queue: data order matches and flags are consistent.
